// File: rtl/muldiv_unit_pkg.sv
// Shared funct3 encodings, divider state type and width default for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            START;
  logic [2:0]      SELECT;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            FLUSH;
  logic            READY;
  logic            BUSY;
  logic            VALID_OUT;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, SELECT, DATA1, DATA2, FLUSH,
    input  READY, BUSY, VALID_OUT, RESULT
  );

  modport slave (
    input  START, SELECT, DATA1, DATA2, FLUSH,
    output READY, BUSY, VALID_OUT, RESULT
  );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes; one quotient bit per step.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   count;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   diff;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign diff = {remainder, quotient[XLEN-1]} - {1'b0, dvs};
  assign last = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      count     <= CW'(XLEN - 1);
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        remainder <= diff[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= {remainder[XLEN-2:0], quotient[XLEN-1]};
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier plus iterative divider sharing one result port.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  muldiv_unit_if.slave bus
);

  div_state_e state, state_n;

  logic ready, accept, mul_accept, div_accept;
  logic mul_empty, mul_done, div_done;
  logic [XLEN-1:0] result, result_q;

  assign ready      = (state == DIV_IDLE) & (~bus.SELECT[2] | mul_empty);
  assign accept     = bus.START & ready & ~bus.FLUSH;
  assign mul_accept = accept & ~bus.SELECT[2];
  assign div_accept = accept & bus.SELECT[2];

  // ---------------- multiplier ----------------
  logic a_signed, b_signed, take_high;
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0] mul_word;

  always_comb begin
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    take_high = 1'b0;
    case (bus.SELECT)
      F3_MUL:    take_high = 1'b0;
      F3_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; take_high = 1'b1; end
      F3_MULHSU: begin a_signed = 1'b1; take_high = 1'b1; end
      F3_MULHU:  take_high = 1'b1;
      default:   take_high = 1'b0;
    endcase
  end

  assign mul_a    = {{XLEN{a_signed & bus.DATA1[XLEN-1]}}, bus.DATA1};
  assign mul_b    = {{XLEN{b_signed & bus.DATA2[XLEN-1]}}, bus.DATA2};
  assign product  = mul_a * mul_b;
  assign mul_word = take_high ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];

  logic [MUL_STAGES-1:0]           pipe_vld;
  logic [MUL_STAGES:0]             vld_chain;
  logic [MUL_STAGES-1:0][XLEN-1:0] pipe_data;
  logic [MUL_STAGES:0][XLEN-1:0]   data_chain;

  // Chains prepend the issue-side value so the shift works for any depth including 1.
  assign vld_chain  = {pipe_vld, mul_accept};
  assign data_chain = {pipe_data, mul_word};
  assign mul_empty  = ~|pipe_vld;
  assign mul_done   = vld_chain[MUL_STAGES];

  always_ff @(posedge CLK) begin
    if (!RESET_N || bus.FLUSH) pipe_vld <= '0;
    else                       pipe_vld <= vld_chain[MUL_STAGES-1:0];
  end

  always_ff @(posedge CLK) begin
    pipe_data <= data_chain[MUL_STAGES-1:0];
  end

  // ---------------- divider ----------------
  logic div_signed, div_rem, neg1, neg2, by_zero, overflow, fast;
  logic [XLEN-1:0] abs1, abs2, fast_value, fix_value, core_q, core_r, div_res;
  logic neg_q, neg_r, op_rem, core_last;

  always_comb begin
    div_signed = 1'b0;
    div_rem    = 1'b0;
    case (bus.SELECT)
      F3_DIV:  div_signed = 1'b1;
      F3_DIVU: div_signed = 1'b0;
      F3_REM:  begin div_signed = 1'b1; div_rem = 1'b1; end
      F3_REMU: div_rem = 1'b1;
      default: div_rem = 1'b0;
    endcase
  end

  assign neg1     = div_signed & bus.DATA1[XLEN-1];
  assign neg2     = div_signed & bus.DATA2[XLEN-1];
  assign abs1     = neg1 ? -bus.DATA1 : bus.DATA1;
  assign abs2     = neg2 ? -bus.DATA2 : bus.DATA2;
  assign by_zero  = (bus.DATA2 == '0);
  assign overflow = div_signed & (bus.DATA1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.DATA2);
  assign fast     = by_zero | overflow;

  always_comb begin
    if (by_zero) fast_value = div_rem ? bus.DATA1 : '1;
    else         fast_value = div_rem ? '0 : bus.DATA1;
  end

  assign fix_value = op_rem ? (neg_r ? -core_r : core_r) : (neg_q ? -core_q : core_q);

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (div_accept & ~fast),
    .step      (state == DIV_RUN),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (core_q),
    .remainder (core_r),
    .last      (core_last)
  );

  always_ff @(posedge CLK) begin
    if (div_accept) begin
      neg_q  <= neg1 ^ neg2;
      neg_r  <= neg1;
      op_rem <= div_rem;
    end
    if (div_accept && fast) div_res <= fast_value;
    else if (state == DIV_FIX) div_res <= fix_value;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N || bus.FLUSH) state <= DIV_IDLE;
    else                       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: if (div_accept) state_n = fast ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (core_last) state_n = DIV_FIX;
      DIV_FIX:  state_n = DIV_DONE;
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end

  // ---------------- result port ----------------
  assign div_done = (state == DIV_DONE);

  always_comb begin
    result = result_q;
    if (mul_done)      result = data_chain[MUL_STAGES];
    else if (div_done) result = div_res;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) result_q <= '0;
    else          result_q <= result;
  end

  assign bus.READY     = ready;
  assign bus.BUSY      = ~mul_empty | (state != DIV_IDLE);
  assign bus.VALID_OUT = mul_done | div_done;
  assign bus.RESULT    = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle output comparison.
module tb_muldiv_unit;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MUL_STAGES = 2;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  muldiv_unit_if #(.XLEN(XLEN)) bus();

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int div_free = 0;
  int mul_empty = 0;
  bit checking = 1'b0;
  logic [31:0] last_result = '0;
  logic [31:0] exp_res [int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_STAGES;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 2;
  endfunction

  function automatic bit model_ready(input logic [2:0] f, input int d);
    return (d >= div_free) && (!f[2] || d >= mul_empty);
  endfunction

  // Model update: sees exactly what the bench drives at each rising edge.
  always @(posedge CLK) begin
    int c, l;
    int keys[$];
    keys.delete();
    c = cyc;
    if (!RESET_N) begin
      exp_res.delete();
      div_free = c + 1;
      mul_empty = c + 1;
      last_result = '0;
    end else if (bus.FLUSH) begin
      foreach (exp_res[k]) if (k > c) keys.push_back(k);
      foreach (keys[i]) exp_res.delete(keys[i]);
      if (div_free > c + 1) div_free = c + 1;
      if (mul_empty > c + 1) mul_empty = c + 1;
    end else if (bus.START && model_ready(bus.SELECT, c)) begin
      l = latency(bus.SELECT, bus.DATA1, bus.DATA2);
      exp_res[c + l] = ref_result(bus.SELECT, bus.DATA1, bus.DATA2);
      if (bus.SELECT[2]) div_free = c + l + 1;
      else mul_empty = c + l + 1;
    end
    cyc = c + 1;
  end

  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (checking) begin
        check("ready", 32'(bus.READY), 32'(model_ready(bus.SELECT, cyc)));
        check("busy", 32'(bus.BUSY), 32'((cyc < div_free) || (cyc < mul_empty)));
        if (exp_res.exists(cyc)) begin
          check("valid_hi", 32'(bus.VALID_OUT), 32'd1);
          check("result", bus.RESULT, exp_res[cyc]);
          last_result = exp_res[cyc];
          exp_res.delete(cyc);
        end else begin
          check("valid_lo", 32'(bus.VALID_OUT), 32'd0);
          check("result_hold", bus.RESULT, last_result);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.FLUSH = 1'b0;
    bus.SELECT = f;
    bus.DATA1 = a;
    bus.DATA2 = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.START = 1'b0;
      bus.FLUSH = 1'b0;
    end
  endtask

  task automatic flush(input logic with_start);
    @(negedge CLK);
    bus.FLUSH = 1'b1;
    bus.START = with_start;
    bus.SELECT = 3'd0;
    bus.DATA1 = 32'd9;
    bus.DATA2 = 32'd9;
  endtask

  initial begin
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    bus.SELECT = 3'd0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;

    // Hand-computed values pinning the reference model.
    check("pin_mul",    ref_result(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000001);
    check("pin_mulhu",  ref_result(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("pin_mulh",   ref_result(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("pin_mulhsu", ref_result(3'd2, 32'hFFFFFFFF, 32'h00000002), 32'hFFFFFFFF);
    check("pin_div",    ref_result(3'd4, 32'hFFFFFFF9, 32'h00000002), 32'hFFFFFFFD);
    check("pin_rem",    ref_result(3'd6, 32'hFFFFFFF9, 32'h00000002), 32'hFFFFFFFF);
    check("pin_divu0",  ref_result(3'd5, 32'h00000005, 32'h00000000), 32'hFFFFFFFF);
    check("pin_remu0",  ref_result(3'd7, 32'h00000005, 32'h00000000), 32'h00000005);
    check("pin_divovf", ref_result(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    check("pin_lat_div", 32'(latency(3'd4, 32'hFFFFFFF9, 32'd2)), 32'd34);
    check("pin_lat_fast", 32'(latency(3'd5, 32'd5, 32'd0)), 32'd1);
    check("pin_lat_mul", 32'(latency(3'd0, 32'd3, 32'd4)), 32'd2);

    repeat (2) @(negedge CLK);
    #1;
    check("rst_result", bus.RESULT, 32'd0);
    check("rst_valid", 32'(bus.VALID_OUT), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_ready", 32'(bus.READY), 32'd1);
    checking = 1'b1;
    RESET_N = 1'b1;

    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd1, 32'h80000000, 32'h80000000);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
    idle(1);
    issue(3'd0, 32'd3, 32'd4);
    issue(3'd0, 32'd5, 32'd6);
    issue(3'd0, 32'd7, 32'd8);
    issue(3'd1, 32'hFFFFFFF9, 32'd3);
    idle(3);

    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    idle(3);
    issue(3'd0, 32'd9, 32'd9);
    issue(3'd5, 32'd100, 32'd7);
    idle(38);
    issue(3'd6, 32'hFFFFFFF9, 32'd2);
    idle(36);

    issue(3'd5, 32'd5, 32'd0);
    idle(1);
    issue(3'd7, 32'd5, 32'd0);
    idle(1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF);
    idle(1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF);
    idle(2);
    issue(3'd5, 32'hFFFFFFFF, 32'd10);
    idle(36);
    issue(3'd7, 32'd1000, 32'hFFFFFFF1);
    idle(36);
    issue(3'd6, 32'd17, 32'hFFFFFFFB);
    idle(36);

    issue(3'd4, 32'd1000, 32'd3);
    idle(9);
    flush(1'b1);
    idle(3);
    issue(3'd0, 32'd3, 32'd4);
    flush(1'b0);
    idle(3);
    issue(3'd0, 32'd2, 32'd2);
    idle(4);

    issue(3'd5, 32'd77, 32'd5);
    idle(5);
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(3);
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0);
    idle(5);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
